// File: rtl/gdt_descriptor_loader_if.sv
// Bundle of request, memory-read and response signals for the GDT loader.
// The loader sits on the slave modport; the requester/memory side on master.
interface gdt_descriptor_loader_if;
    // request side
    logic        req_valid;
    logic [15:0] req_selector;
    logic        req_ready;
    logic [31:0] GDTR_base;
    logic [15:0] GDTR_limit;

    // memory read side
    logic        mem_read_request;
    logic [31:0] mem_address;
    logic        mem_read_ready;
    logic [31:0] mem_read_data;

    // response side
    logic        resp_valid;
    logic        resp_fault;
    logic [2:0]  resp_fault_code;
    logic [15:0] resp_error_code;
    logic [63:0] desc_raw;
    logic [31:0] desc_base;
    logic [31:0] desc_limit;
    logic [3:0]  desc_type;
    logic [1:0]  desc_dpl;
    logic        desc_s;
    logic        desc_p;
    logic        desc_db;
    logic        desc_g;

    modport master (
        output req_valid,
        output req_selector,
        output GDTR_base,
        output GDTR_limit,
        output mem_read_ready,
        output mem_read_data,
        input  req_ready,
        input  mem_read_request,
        input  mem_address,
        input  resp_valid,
        input  resp_fault,
        input  resp_fault_code,
        input  resp_error_code,
        input  desc_raw,
        input  desc_base,
        input  desc_limit,
        input  desc_type,
        input  desc_dpl,
        input  desc_s,
        input  desc_p,
        input  desc_db,
        input  desc_g
    );

    modport slave (
        input  req_valid,
        input  req_selector,
        input  GDTR_base,
        input  GDTR_limit,
        input  mem_read_ready,
        input  mem_read_data,
        output req_ready,
        output mem_read_request,
        output mem_address,
        output resp_valid,
        output resp_fault,
        output resp_fault_code,
        output resp_error_code,
        output desc_raw,
        output desc_base,
        output desc_limit,
        output desc_type,
        output desc_dpl,
        output desc_s,
        output desc_p,
        output desc_db,
        output desc_g
    );
endinterface

// File: rtl/gdt_descriptor_loader.sv
// Checks a segment selector against GDTR, fetches its 8-byte descriptor
// as two dword reads and decodes it. Optional build macro:
// GDT_DESCRIPTOR_PRESENT_CHECK_EN - fault (code 4) on a not-present descriptor.
module gdt_descriptor_loader #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input logic                    clock,
    input logic                    reset,
    gdt_descriptor_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ_LO,
        READ_HI,
        DONE
    } state_t;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_NULL    = 3'd1;
    localparam logic [2:0] CODE_TI      = 3'd2;
    localparam logic [2:0] CODE_LIMIT   = 3'd3;
    localparam logic [2:0] CODE_NP      = 3'd4;
    localparam logic [2:0] CODE_TIMEOUT = 3'd5;

    localparam logic [15:0] ERR_MASK = 16'hFFFC;

    // last wait count before a read is declared timed out
    localparam logic [31:0] WAIT_LAST =
        (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

`ifdef GDT_DESCRIPTOR_PRESENT_CHECK_EN
    localparam bit PRESENT_CHECK = 1'b1;
`else
    localparam bit PRESENT_CHECK = 1'b0;
`endif

    state_t      state;
    state_t      next_state;

    // latched at acceptance / capture
    logic [15:0] sel_q;
    logic [31:0] addr_q;
    logic [31:0] lo_q;
    logic [31:0] wait_cnt;

    // held response
    logic [63:0] raw_q;
    logic        fault_q;
    logic [2:0]  code_q;
    logic [15:0] err_q;

    // request decode
    logic [12:0] req_index;
    logic        req_ti;
    logic        limit_hit;
    logic [2:0]  check_code;

    // FSM strobes
    logic        accept;
    logic        reading;
    logic        lo_fire;
    logic        hi_fire;
    logic        timeout_hit;
    logic        wait_expired;
    logic        not_present;

    // descriptor decode
    logic [31:0] hi_word;
    logic [31:0] lo_word;
    logic [19:0] raw_limit;

    assign req_index = bus.req_selector[15:3];
    assign req_ti    = bus.req_selector[2];

    // last byte of the descriptor must lie within the table limit
    assign limit_hit = {1'b0, req_index, 3'b111} > {1'b0, bus.GDTR_limit};

    assign reading = (state == READ_LO) || (state == READ_HI);

    assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    assign not_present = PRESENT_CHECK && !bus.mem_read_data[15];

    // selector checks in priority order: TI, null index, table limit
    always_comb begin
        check_code = CODE_NONE;
        if (req_ti) begin
            check_code = CODE_TI;
        end else if (req_index == 13'd0) begin
            check_code = CODE_NULL;
        end else if (limit_hit) begin
            check_code = CODE_LIMIT;
        end
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state and per-cycle strobes
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        lo_fire     = 1'b0;
        hi_fire     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (check_code != CODE_NONE) begin
                        next_state = DONE;
                    end else begin
                        next_state = READ_LO;
                    end
                end
            end
            READ_LO: begin
                if (bus.mem_read_ready) begin
                    lo_fire    = 1'b1;
                    next_state = READ_HI;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            READ_HI: begin
                if (bus.mem_read_ready) begin
                    hi_fire    = 1'b1;
                    next_state = DONE;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // request latch, read address and per-read wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q    <= '0;
            addr_q   <= '0;
            lo_q     <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                sel_q  <= bus.req_selector;
                addr_q <= bus.GDTR_base + {16'd0, req_index, 3'b000};
            end
            if (lo_fire) begin
                lo_q   <= bus.mem_read_data;
                addr_q <= addr_q + 32'd4;
            end
            if (reading && !bus.mem_read_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + 32'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // response registers, updated only on the edge that enters DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
            err_q   <= '0;
        end else begin
            if (accept && (check_code != CODE_NONE)) begin
                raw_q   <= '0;
                fault_q <= 1'b1;
                code_q  <= check_code;
                err_q   <= bus.req_selector & ERR_MASK;
            end
            if (timeout_hit) begin
                raw_q   <= '0;
                fault_q <= 1'b1;
                code_q  <= CODE_TIMEOUT;
                err_q   <= sel_q & ERR_MASK;
            end
            if (hi_fire) begin
                raw_q <= {bus.mem_read_data, lo_q};
                if (not_present) begin
                    fault_q <= 1'b1;
                    code_q  <= CODE_NP;
                    err_q   <= sel_q & ERR_MASK;
                end else begin
                    fault_q <= 1'b0;
                    code_q  <= CODE_NONE;
                    err_q   <= '0;
                end
            end
        end
    end

    assign hi_word   = raw_q[63:32];
    assign lo_word   = raw_q[31:0];
    assign raw_limit = {hi_word[19:16], lo_word[15:0]};

    assign bus.req_ready        = (state == IDLE);
    assign bus.mem_read_request = reading;
    assign bus.mem_address      = addr_q;

    assign bus.resp_valid      = (state == DONE);
    assign bus.resp_fault      = fault_q;
    assign bus.resp_fault_code = code_q;
    assign bus.resp_error_code = err_q;

    assign bus.desc_raw   = raw_q;
    assign bus.desc_base  = {hi_word[31:24], hi_word[7:0], lo_word[31:16]};
    assign bus.desc_limit = hi_word[23] ? {raw_limit, 12'hFFF}
                                        : {12'h000, raw_limit};
    assign bus.desc_type  = hi_word[11:8];
    assign bus.desc_dpl   = hi_word[14:13];
    assign bus.desc_s     = hi_word[12];
    assign bus.desc_p     = hi_word[15];
    assign bus.desc_db    = hi_word[22];
    assign bus.desc_g     = hi_word[23];

endmodule
